// File: rtl/rx_descramble_merge_lpif.sv
// Receive-side PHY core: per-lane descrambling of PIPE data, merging of the
// active lanes into one byte stream, and the registered LPIF pl_* outputs.
module rx_descramble_merge_lpif #(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   GEN,
  input  logic         turnOff,
  input  logic [15:0]  PIPEDataValid,
  input  logic [511:0] PIPEData,
  input  logic [63:0]  PIPEDataK,
  input  logic [31:0]  PIPESyncHeader,
  input  logic [4:0]   numberOfDetectedLanes,
  output logic [511:0] LMCData,
  output logic [63:0]  LMCDataK,
  output logic         LMCValid,
  input  logic [63:0]  tlpstart,
  input  logic [63:0]  dllpstart,
  input  logic [63:0]  tlpend,
  input  logic [63:0]  dllpend,
  input  logic [63:0]  edb,
  input  logic [63:0]  packetValid,
  input  logic [511:0] packetData,
  output logic [63:0]  pl_tlpstart,
  output logic [63:0]  pl_dllpstart,
  output logic [63:0]  pl_tlpend,
  output logic [63:0]  pl_dllpend,
  output logic [63:0]  pl_tlpedb,
  output logic [63:0]  pl_valid,
  output logic [511:0] pl_data,
  output logic [2:0]   pl_speedmode
);

  localparam logic [15:0] lfsrSeed16 = 16'hFFFF;
  localparam logic [15:0] lfsrTaps16 = 16'h0039;    // x^5+x^4+x^3+1
  localparam logic [22:0] lfsrSeed23 = 23'h1DBFBC;
  localparam logic [22:0] lfsrTaps23 = 23'h210125;  // x^21+x^16+x^8+x^5+x^2+1

  // Galois LFSRs: the key bit for each data bit is the MSB before that step.
  function automatic logic [7:0] key16(input logic [15:0] s);
    logic [15:0] r;
    logic [7:0]  k;
    r = s;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      k[i] = r[15];
      r = {r[14:0], 1'b0} ^ (r[15] ? lfsrTaps16 : 16'h0000);
    end
    return k;
  endfunction

  function automatic logic [15:0] next16(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = {r[14:0], 1'b0} ^ (r[15] ? lfsrTaps16 : 16'h0000);
    return r;
  endfunction

  function automatic logic [7:0] key23(input logic [22:0] s);
    logic [22:0] r;
    logic [7:0]  k;
    r = s;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      k[i] = r[22];
      r = {r[21:0], 1'b0} ^ (r[22] ? lfsrTaps23 : 23'h000000);
    end
    return k;
  endfunction

  function automatic logic [22:0] next23(input logic [22:0] s);
    logic [22:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = {r[21:0], 1'b0} ^ (r[22] ? lfsrTaps23 : 23'h000000);
    return r;
  endfunction

  logic              isGen12;
  int                curBytes;
  int                curLanes;
  logic [15:0][15:0] lfsr16, nxt16;
  logic [15:0][22:0] lfsr23, nxt23;
  logic [15:0][31:0] descData, dsData;
  logic [15:0][3:0]  descK, dsK;
  logic [15:0]       dsValid;
  logic [2:0]        dsBytes;
  logic [4:0]        dsLanes;
  logic [511:0]      mergeData;
  logic [63:0]       mergeK;
  logic              mergeValid;
  logic [511:0]      plDataNext;
  logic [2:0]        speedNext;

  // Decode link speed into bytes per lane and scrambler family; clamp lane count.
  always_comb begin
    isGen12  = 1'b1;
    curBytes = GEN1_PIPEWIDTH / 8;
    case (GEN)
      3'd2: curBytes = GEN2_PIPEWIDTH / 8;
      3'd3: begin isGen12 = 1'b0; curBytes = GEN3_PIPEWIDTH / 8; end
      3'd4: begin isGen12 = 1'b0; curBytes = GEN4_PIPEWIDTH / 8; end
      3'd5: begin isGen12 = 1'b0; curBytes = GEN5_PIPEWIDTH / 8; end
      default: ;
    endcase
    if (numberOfDetectedLanes == 5'd0)       curLanes = 1;
    else if (numberOfDetectedLanes > 5'd16)  curLanes = 16;
    else                                     curLanes = int'(numberOfDetectedLanes);
  end

  // Per-lane descrambling, bytes taken LSB first, LFSR state chained byte to byte.
  always_comb begin
    nxt16    = lfsr16;
    nxt23    = lfsr23;
    descData = '0;
    descK    = '0;
    for (int l = 0; l < 16; l++) begin
      for (int j = 0; j < 4; j++) begin
        if (j < curBytes) begin
          descData[l][8*j +: 8] = PIPEData[32*l + 8*j +: 8];
          descK[l][j]           = PIPEDataK[4*l + j];
          if (PIPEDataValid[l] && !turnOff) begin
            if (isGen12) begin
              if (PIPEDataK[4*l + j]) begin
                if (PIPEData[32*l + 8*j +: 8] == 8'hBC)      nxt16[l] = lfsrSeed16;
                else if (PIPEData[32*l + 8*j +: 8] != 8'h1C) nxt16[l] = next16(nxt16[l]);
              end else begin
                descData[l][8*j +: 8] = PIPEData[32*l + 8*j +: 8] ^ key16(nxt16[l]);
                nxt16[l] = next16(nxt16[l]);
              end
            end else begin
              if (PIPESyncHeader[2*l +: 2] == 2'b10) begin
                descData[l][8*j +: 8] = PIPEData[32*l + 8*j +: 8] ^ key23(nxt23[l]);
                nxt23[l] = next23(nxt23[l]);
              end else if (PIPESyncHeader[2*l +: 2] == 2'b01 && j == 0 &&
                           PIPEData[32*l +: 8] == 8'h00) begin
                nxt23[l] = lfsrSeed23;
              end
            end
          end
        end
      end
    end
  end

  // Descrambler stage register; byte and lane counts travel with the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr16  <= {16{lfsrSeed16}};
      lfsr23  <= {16{lfsrSeed23}};
      dsData  <= '0;
      dsK     <= '0;
      dsValid <= '0;
      dsBytes <= 3'd1;
      dsLanes <= 5'd1;
    end else begin
      lfsr16  <= nxt16;
      lfsr23  <= nxt23;
      dsData  <= descData;
      dsK     <= descK;
      dsValid <= PIPEDataValid;
      dsBytes <= 3'(curBytes);
      dsLanes <= 5'(curLanes);
    end
  end

  // Interleave active lanes: merged byte s*N+l takes lane l byte s.
  always_comb begin
    mergeData  = '0;
    mergeK     = '0;
    mergeValid = (dsLanes != 5'd0);
    for (int l = 0; l < 16; l++) begin
      if (l < int'(dsLanes)) begin
        mergeValid = mergeValid & dsValid[l];
        for (int s = 0; s < 4; s++) begin
          if (s < int'(dsBytes)) begin
            mergeData[(s*int'(dsLanes) + l)*8 +: 8] = dsData[l][8*s +: 8];
            mergeK[s*int'(dsLanes) + l]             = dsK[l][s];
          end
        end
      end
    end
  end

  // Merged stream output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LMCData  <= '0;
      LMCDataK <= '0;
      LMCValid <= 1'b0;
    end else begin
      LMCData  <= mergeData;
      LMCDataK <= mergeK;
      LMCValid <= mergeValid;
    end
  end

  // Blank packet bytes that are not valid and map GEN to the LPIF speed code.
  always_comb begin
    plDataNext = '0;
    for (int b = 0; b < 64; b++) begin
      if (packetValid[b]) plDataNext[8*b +: 8] = packetData[8*b +: 8];
    end
    speedNext = 3'd0;
    if (GEN >= 3'd1 && GEN <= 3'd5) speedNext = GEN - 3'd1;
  end

  // LPIF output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pl_tlpstart  <= '0;
      pl_dllpstart <= '0;
      pl_tlpend    <= '0;
      pl_dllpend   <= '0;
      pl_tlpedb    <= '0;
      pl_valid     <= '0;
      pl_data      <= '0;
      pl_speedmode <= 3'd0;
    end else begin
      pl_tlpstart  <= tlpstart  & packetValid;
      pl_dllpstart <= dllpstart & packetValid;
      pl_tlpend    <= tlpend    & packetValid;
      pl_dllpend   <= dllpend   & packetValid;
      pl_tlpedb    <= edb       & packetValid;
      pl_valid     <= packetValid;
      pl_data      <= plDataNext;
      pl_speedmode <= speedNext;
    end
  end

endmodule

// File: tb/tb_rx_descramble_merge_lpif.sv
// Bench for rx_descramble_merge_lpif: table vectors plus random traffic, merged
// stream checked through a scoreboard queue, LPIF stage checked one clock later.
module tb_rx_descramble_merge_lpif;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [2:0]   GEN;
  logic         turnOff;
  logic [15:0]  PIPEDataValid;
  logic [511:0] PIPEData;
  logic [63:0]  PIPEDataK;
  logic [31:0]  PIPESyncHeader;
  logic [4:0]   numberOfDetectedLanes;
  logic [511:0] LMCData;
  logic [63:0]  LMCDataK;
  logic         LMCValid;
  logic [63:0]  tlpstart, dllpstart, tlpend, dllpend, edb, packetValid;
  logic [511:0] packetData;
  logic [63:0]  pl_tlpstart, pl_dllpstart, pl_tlpend, pl_dllpend, pl_tlpedb, pl_valid;
  logic [511:0] pl_data;
  logic [2:0]   pl_speedmode;

  rx_descramble_merge_lpif dut (
    .clk(clk), .reset(reset), .GEN(GEN), .turnOff(turnOff),
    .PIPEDataValid(PIPEDataValid), .PIPEData(PIPEData), .PIPEDataK(PIPEDataK),
    .PIPESyncHeader(PIPESyncHeader), .numberOfDetectedLanes(numberOfDetectedLanes),
    .LMCData(LMCData), .LMCDataK(LMCDataK), .LMCValid(LMCValid),
    .tlpstart(tlpstart), .dllpstart(dllpstart), .tlpend(tlpend), .dllpend(dllpend),
    .edb(edb), .packetValid(packetValid), .packetData(packetData),
    .pl_tlpstart(pl_tlpstart), .pl_dllpstart(pl_dllpstart), .pl_tlpend(pl_tlpend),
    .pl_dllpend(pl_dllpend), .pl_tlpedb(pl_tlpedb), .pl_valid(pl_valid),
    .pl_data(pl_data), .pl_speedmode(pl_speedmode)
  );

  typedef struct {
    logic [2:0]  gen;
    bit          off;
    logic [4:0]  n;
    logic [15:0] v;
    logic [31:0] l0;
    logic [31:0] l1;
    logic [3:0]  k0;
    logic [1:0]  s0;
    bit          chkD;
    logic [31:0] expLo;
    bit          chkV;
    bit          expV;
  } vec_t;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         v;
    bit           chkD;
    logic [31:0]  expLo;
    bit           chkV;
    bit           expV;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m16[16];
  logic [22:0] m23[16];
  vec_t        tbl[12];
  int          nVec = 0;
  int          nErr = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int l = 0; l < 16; l++) begin
      m16[l] = 16'hFFFF;
      m23[l] = 23'h1DBFBC;
    end
    sb.delete();
  endtask

  // Reference: bit-serial scrambler per lane, then lane interleave.
  task automatic modelPush(input logic [2:0] g, input bit off, input logic [4:0] n,
                           input logic [15:0] v, input logic [511:0] d, input logic [63:0] k,
                           input logic [31:0] sh, input bit chkD, input logic [31:0] expLo,
                           input bit chkV, input bit expV);
    exp_t       e;
    int         bb, nn;
    bit         g12;
    logic [7:0] b;
    bb  = 1;
    g12 = 1;
    if (g == 3'd2) bb = 2;
    if (g == 3'd3) begin bb = 4; g12 = 0; end
    if (g == 3'd4 || g == 3'd5) g12 = 0;
    nn = (n == 5'd0) ? 1 : ((n > 5'd16) ? 16 : int'(n));
    e.d = '0; e.k = '0; e.v = 1'b1;
    for (int l = 0; l < 16; l++) begin
      if (l < nn) e.v = e.v & v[l];
      for (int j = 0; j < bb; j++) begin
        b = d[32*l + 8*j +: 8];
        if (v[l] && !off) begin
          if (g12) begin
            if (k[4*l + j]) begin
              if (b == 8'hBC) m16[l] = 16'hFFFF;
              else if (b != 8'h1C)
                for (int i = 0; i < 8; i++)
                  m16[l] = {m16[l][14:0], 1'b0} ^ (m16[l][15] ? 16'h0039 : 16'h0000);
            end else begin
              for (int i = 0; i < 8; i++) begin
                b[i] = b[i] ^ m16[l][15];
                m16[l] = {m16[l][14:0], 1'b0} ^ (m16[l][15] ? 16'h0039 : 16'h0000);
              end
            end
          end else begin
            if (sh[2*l +: 2] == 2'b10) begin
              for (int i = 0; i < 8; i++) begin
                b[i] = b[i] ^ m23[l][22];
                m23[l] = {m23[l][21:0], 1'b0} ^ (m23[l][22] ? 23'h210125 : 23'h0);
              end
            end else if (sh[2*l +: 2] == 2'b01 && j == 0 && b == 8'h00) begin
              m23[l] = 23'h1DBFBC;
            end
          end
        end
        if (l < nn) begin
          e.d[(j*nn + l)*8 +: 8] = b;
          e.k[j*nn + l] = k[4*l + j];
        end
      end
    end
    e.chkD = chkD; e.expLo = expLo; e.chkV = chkV; e.expV = expV;
    sb.push_back(e);
  endtask

  task automatic stepVec(input logic [2:0] g, input bit off, input logic [4:0] n,
                         input logic [15:0] v, input logic [511:0] d, input logic [63:0] k,
                         input logic [31:0] sh, input bit chkD, input logic [31:0] expLo,
                         input bit chkV, input bit expV, input bit forceTlp);
    exp_t         e;
    logic [63:0]  pv, ts, dst, te, de, eb;
    logic [511:0] pd, expPd;
    logic [2:0]   expSpd;
    @(negedge clk);
    GEN = g; turnOff = off; numberOfDetectedLanes = n; PIPEDataValid = v;
    PIPEData = d; PIPEDataK = k; PIPESyncHeader = sh;
    pv  = {$urandom, $urandom}; ts = {$urandom, $urandom}; dst = {$urandom, $urandom};
    te  = {$urandom, $urandom}; de = {$urandom, $urandom}; eb  = {$urandom, $urandom};
    for (int w = 0; w < 16; w++) pd[32*w +: 32] = $urandom;
    if (forceTlp) begin pv[0] = 1'b1; ts[0] = 1'b1; end
    packetValid = pv; tlpstart = ts; dllpstart = dst; tlpend = te; dllpend = de; edb = eb;
    packetData = pd;
    expPd = '0;
    for (int b = 0; b < 64; b++) if (pv[b]) expPd[8*b +: 8] = pd[8*b +: 8];
    expSpd = (g >= 3'd1 && g <= 3'd5) ? g - 3'd1 : 3'd0;
    modelPush(g, off, n, v, d, k, sh, chkD, expLo, chkV, expV);
    @(posedge clk);
    #1;
    check("pl_data", pl_data, expPd);
    check("pl_tlpstart", pl_tlpstart, ts & pv);
    check("pl_dllpstart", pl_dllpstart, dst & pv);
    check("pl_tlpend", pl_tlpend, te & pv);
    check("pl_dllpend", pl_dllpend, de & pv);
    check("pl_tlpedb", pl_tlpedb, eb & pv);
    check("pl_valid", pl_valid, pv);
    check("pl_speedmode", pl_speedmode, expSpd);
    if (forceTlp) check("pl_tlpstart_byte0", pl_tlpstart[0], 1'b1);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check("LMCValid", LMCValid, e.v);
      if (e.v) begin
        check("LMCData", LMCData, e.d);
        check("LMCDataK", LMCDataK, e.k);
      end
      if (e.chkD) check("LMCData_lo_const", LMCData[31:0], e.expLo);
      if (e.chkV) check("LMCValid_const", LMCValid, e.expV);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_LMCData"}, LMCData, '0);
    check({tag, "_LMCDataK"}, LMCDataK, '0);
    check({tag, "_LMCValid"}, LMCValid, '0);
    check({tag, "_pl_valid"}, pl_valid, '0);
    check({tag, "_pl_data"}, pl_data, '0);
    check({tag, "_pl_tlpstart"}, pl_tlpstart, '0);
    check({tag, "_pl_speedmode"}, pl_speedmode, '0);
  endtask

  initial begin
    logic [511:0] d;
    logic [63:0]  k;
    logic [31:0]  sh;
    logic [15:0]  v;
    logic [2:0]   g;
    logic [4:0]   n;
    bit           off;

    reset = 1'b1; GEN = 3'd1; turnOff = 1'b0; PIPEDataValid = '0; PIPEData = '0;
    PIPEDataK = '0; PIPESyncHeader = '0; numberOfDetectedLanes = 5'd1;
    tlpstart = '0; dllpstart = '0; tlpend = '0; dllpend = '0; edb = '0;
    packetValid = '0; packetData = '0;
    #1;
    checkAllZero("por");
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();

    tbl[0]  = '{gen:3'd1, off:0, n:5'd1, v:16'h0001, l0:32'h0000_00BC, l1:32'h0, k0:4'h1, s0:2'b00,
                chkD:1, expLo:32'h0000_00BC, chkV:1, expV:1};
    tbl[1]  = '{gen:3'd1, off:0, n:5'd1, v:16'h0001, l0:32'h0, l1:32'h0, k0:4'h0, s0:2'b00,
                chkD:1, expLo:32'h0000_00FF, chkV:1, expV:1};
    tbl[2]  = '{gen:3'd1, off:0, n:5'd1, v:16'h0001, l0:32'h0, l1:32'h0, k0:4'h0, s0:2'b00,
                chkD:1, expLo:32'h0000_0017, chkV:1, expV:1};
    tbl[3]  = '{gen:3'd1, off:0, n:5'd1, v:16'h0001, l0:32'h0, l1:32'h0, k0:4'h0, s0:2'b00,
                chkD:1, expLo:32'h0000_00C0, chkV:1, expV:1};
    tbl[4]  = '{gen:3'd1, off:1, n:5'd1, v:16'h0001, l0:32'h0000_00AA, l1:32'h0, k0:4'h0, s0:2'b00,
                chkD:1, expLo:32'h0000_00AA, chkV:1, expV:1};
    tbl[5]  = '{gen:3'd2, off:1, n:5'd2, v:16'h0003, l0:32'h0000_2211, l1:32'h0000_4433, k0:4'h0,
                s0:2'b00, chkD:1, expLo:32'h4422_3311, chkV:1, expV:1};
    tbl[6]  = '{gen:3'd2, off:0, n:5'd2, v:16'h0001, l0:32'h0000_5566, l1:32'h0000_7788, k0:4'h0,
                s0:2'b00, chkD:0, expLo:32'h0, chkV:1, expV:0};
    tbl[7]  = '{gen:3'd3, off:0, n:5'd1, v:16'h0001, l0:32'hAAAA_AAAA, l1:32'h0, k0:4'h0, s0:2'b01,
                chkD:1, expLo:32'hAAAA_AAAA, chkV:1, expV:1};
    tbl[8]  = '{gen:3'd3, off:0, n:5'd1, v:16'h0001, l0:32'hAAAA_AA00, l1:32'h0, k0:4'h0, s0:2'b01,
                chkD:1, expLo:32'hAAAA_AA00, chkV:1, expV:1};
    tbl[9]  = '{gen:3'd3, off:0, n:5'd1, v:16'h0001, l0:32'h0, l1:32'h0, k0:4'h0, s0:2'b10,
                chkD:0, expLo:32'h0, chkV:1, expV:1};
    tbl[10] = '{gen:3'd1, off:0, n:5'd1, v:16'h0001, l0:32'h0000_001C, l1:32'h0, k0:4'h1, s0:2'b00,
                chkD:1, expLo:32'h0000_001C, chkV:1, expV:1};
    tbl[11] = '{gen:3'd1, off:0, n:5'd1, v:16'h0001, l0:32'h0, l1:32'h0, k0:4'h0, s0:2'b00,
                chkD:0, expLo:32'h0, chkV:1, expV:1};

    for (int i = 0; i < 12; i++) begin
      d = '0; k = '0; sh = '0;
      d[31:0] = tbl[i].l0; d[63:32] = tbl[i].l1; k[3:0] = tbl[i].k0; sh[1:0] = tbl[i].s0;
      stepVec(tbl[i].gen, tbl[i].off, tbl[i].n, tbl[i].v, d, k, sh,
              tbl[i].chkD, tbl[i].expLo, tbl[i].chkV, tbl[i].expV, (i == 7));
    end

    for (int r = 0; r < 60; r++) begin
      g   = 3'($urandom_range(0, 7));
      off = ($urandom_range(0, 5) == 0);
      n   = 5'($urandom_range(0, 20));
      v   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
      k   = '0;
      sh  = '0;
      for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
      for (int b = 0; b < 64; b++) begin
        if ($urandom_range(0, 7) == 0) begin
          k[b] = 1'b1;
          case ($urandom_range(0, 2))
            0: d[8*b +: 8] = 8'hBC;
            1: d[8*b +: 8] = 8'h1C;
            default: ;
          endcase
        end
      end
      for (int l = 0; l < 16; l++) begin
        sh[2*l +: 2] = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b10;
        if (sh[2*l +: 2] == 2'b01 && $urandom_range(0, 1) == 0) d[32*l +: 8] = 8'h00;
      end
      stepVec(g, off, n, v, d, k, sh, 0, 32'h0, 0, 0, 0);
    end

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();

    stepVec(3'd1, 0, 5'd1, 16'h0001, 512'h0, 64'h0, 32'h0, 1, 32'h0000_00FF, 1, 1, 0);
    stepVec(3'd3, 0, 5'd4, 16'h000F, {16{32'h1234_5678}}, 64'h0, {16{2'b10}}, 0, 32'h0, 1, 1, 0);
    stepVec(3'd1, 0, 5'd1, 16'h0000, 512'h0, 64'h0, 32'h0, 0, 32'h0, 1, 0, 0);
    stepVec(3'd1, 0, 5'd1, 16'h0000, 512'h0, 64'h0, 32'h0, 0, 32'h0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
